// File: rtl/div_pkg.sv
// Shared definitions for the divider controller: operand width, default step count, FSM states.
package div_pkg;

    localparam int unsigned OpW         = 4;
    localparam int unsigned IterDefault = 5;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StRun  = 3'd2,
        StCapt = 3'd3,
        StOut  = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_ctrl.sv
// Sequencing controller for an external iterative divider datapath.
// Define DIV_CTRL_DZ_EN to short-circuit divide-by-zero straight to the result state.
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned ITER = IterDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OpW-1:0]   in_a,
    input  logic [OpW-1:0]   in_b,
    output logic             div_ld,
    output logic [OpW-1:0]   div_a,
    output logic [OpW-1:0]   div_b,
    input  logic [2*OpW-1:0] div_ra,
    input  logic [OpW-1:0]   div_ry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OpW-1:0]   out_q,
    output logic [OpW-1:0]   out_r,
    output logic             out_dz
);

    localparam int unsigned    CntW    = (ITER > 0) ? $clog2(ITER + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [OpW-1:0]  opa_q, opa_d;
    logic [OpW-1:0]  opb_q, opb_d;
    logic [OpW-1:0]  quo_q, quo_d;
    logic [OpW-1:0]  rem_q, rem_d;
    logic            valid_q, valid_d;
`ifdef DIV_CTRL_DZ_EN
    logic            dz_q, dz_d;
`endif

    // Upper remainder bits belong to the datapath's shift register only.
    logic unused_ra_hi;
    assign unused_ra_hi = ^div_ra[2*OpW-1:OpW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        valid_d = valid_q;
`ifdef DIV_CTRL_DZ_EN
        dz_d    = dz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    opa_d   = in_a;
                    opb_d   = in_b;
                    state_d = StLoad;
`ifdef DIV_CTRL_DZ_EN
                    if (in_b == '0) begin
                        quo_d   = '1;
                        rem_d   = in_a;
                        dz_d    = 1'b1;
                        valid_d = 1'b1;
                        state_d = StOut;
                    end
`endif
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StCapt;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCapt: begin
                quo_d   = div_ry;
                rem_d   = div_ra[OpW-1:0];
                valid_d = 1'b1;
`ifdef DIV_CTRL_DZ_EN
                dz_d    = 1'b0;
`endif
                state_d = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
`ifdef DIV_CTRL_DZ_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
`ifdef DIV_CTRL_DZ_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign div_ld    = (state_q == StLoad);
    assign div_a     = opa_q;
    assign div_b     = opb_q;
    assign out_valid = valid_q;
    assign out_q     = quo_q;
    assign out_r     = rem_q;
`ifdef DIV_CTRL_DZ_EN
    assign out_dz    = dz_q;
`else
    assign out_dz    = 1'b0;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider beside the DUT, transaction-level reference model,
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_div_ctrl;

    localparam int ITER = 5;
`ifdef DIV_CTRL_DZ_EN
    localparam bit DzEn = 1'b1;
`else
    localparam bit DzEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_a = 4'd0;
    logic [3:0] in_b = 4'd0;
    logic       in_ready, div_ld, out_valid, out_dz;
    logic [3:0] div_a, div_b, out_q, out_r;
    logic [7:0] div_ra;
    logic [3:0] div_ry;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    div_ctrl #(.ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .div_ld    (div_ld),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_ra    (div_ra),
        .div_ry    (div_ry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_dz    (out_dz)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    endtask

    // Divider datapath stand-in: result is only correct after ITER step edges following div_ld.
    int unsigned dsteps;
    logic [3:0]  da, db;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dsteps <= ITER;
            div_ry <= 4'd0;
            div_ra <= 8'd0;
            da     <= 4'd0;
            db     <= 4'd0;
        end else if (div_ld) begin
            da     <= div_a;
            db     <= div_b;
            dsteps <= 0;
            div_ry <= 4'($urandom);
            div_ra <= 8'($urandom);
        end else if (dsteps < ITER) begin
            dsteps <= dsteps + 1;
            if (dsteps + 1 == ITER) begin
                div_ry <= (db == 4'd0) ? 4'hF : 4'(da / db);
                div_ra <= {4'($urandom), (db == 4'd0) ? da : 4'(da % db)};
            end else begin
                div_ry <= 4'($urandom);
                div_ra <= 8'($urandom);
            end
        end
    end

    // Reference model: one transaction in flight, tracked by edges since acceptance.
    bit         m_busy = 1'b0;
    int         m_age, m_lat;
    logic [3:0] m_a, m_b, m_q, m_r;
    bit         m_dz;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_a    = in_a;
                m_b    = in_b;
                m_dz   = DzEn && (in_b == 4'd0);
                m_lat  = m_dz ? 0 : ITER + 2;
                m_q    = (in_b == 4'd0) ? 4'hF : 4'(in_a / in_b);
                m_r    = (in_b == 4'd0) ? in_a : 4'(in_a % in_b);
            end
        end else if (m_age >= m_lat && out_ready) begin
            m_busy = 1'b0;
        end else begin
            m_age++;
        end
    end

    bit exp_v;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = m_busy && (m_age >= m_lat);
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("div_ld", 32'(div_ld), 32'(m_busy && !m_dz && m_age == 0));
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            if (m_busy) begin
                chk("div_a", 32'(div_a), 32'(m_a));
                chk("div_b", 32'(div_b), 32'(m_b));
            end
            if (exp_v) begin
                chk("out_q", 32'(out_q), 32'(m_q));
                chk("out_r", 32'(out_r), 32'(m_r));
                chk("out_dz", 32'(out_dz), 32'(m_dz));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_div_ld"}, 32'(div_ld), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_q"}, 32'(out_q), 32'd0);
        chk({tag, "_out_r"}, 32'(out_r), 32'd0);
        chk({tag, "_out_dz"}, 32'(out_dz), 32'd0);
        chk({tag, "_div_a"}, 32'(div_a), 32'd0);
        chk({tag, "_div_b"}, 32'(div_b), 32'd0);
    endtask

    // Offers one operand pair, measures latency and div_ld pulses, optionally stalls the result.
    task automatic op(input logic [3:0] a, input logic [3:0] b, input int hold,
                      input logic [3:0] eq, input logic [3:0] er,
                      output int lat, output int lds,
                      output logic [3:0] q, output logic [3:0] r, output logic dz);
        int g;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b0;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        lds = 0;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            if (div_ld) lds++;
            lat++;
            @(negedge clk);
        end
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
        q  = out_q;
        r  = out_r;
        dz = out_dz;
        in_valid = 1'b1;
        repeat (hold) begin
            in_a = 4'($urandom);
            in_b = 4'($urandom);
            @(negedge clk);
            chk("hold_q", 32'(out_q), 32'(eq));
            chk("hold_r", 32'(out_r), 32'(er));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout t=%0t got=running want=finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, lds;
        logic [3:0] q, r;
        logic dz;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_vals("por");
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;

        op(4'd11, 4'd2, 0, 4'd5, 4'd1, lat, lds, q, r, dz);
        chk("a11b2_lat", 32'(lat), 32'd7);
        chk("a11b2_ld", 32'(lds), 32'd1);
        chk("a11b2_q", 32'(q), 32'd5);
        chk("a11b2_r", 32'(r), 32'd1);
        chk("a11b2_dz", 32'(dz), 32'd0);

        op(4'd15, 4'd1, 0, 4'd15, 4'd0, lat, lds, q, r, dz);
        chk("a15b1_q", 32'(q), 32'd15);
        chk("a15b1_r", 32'(r), 32'd0);

        op(4'd3, 4'd7, 0, 4'd0, 4'd3, lat, lds, q, r, dz);
        chk("a3b7_q", 32'(q), 32'd0);
        chk("a3b7_r", 32'(r), 32'd3);

        op(4'd9, 4'd4, 10, 4'd2, 4'd1, lat, lds, q, r, dz);
        chk("a9b4_q", 32'(q), 32'd2);
        chk("a9b4_r", 32'(r), 32'd1);

        op(4'd6, 4'd0, 0, 4'd15, 4'd6, lat, lds, q, r, dz);
        chk("a6b0_q", 32'(q), 32'd15);
        chk("a6b0_r", 32'(r), 32'd6);
        chk("a6b0_dz", 32'(dz), 32'(DzEn));
        chk("a6b0_lat", 32'(lat), DzEn ? 32'd0 : 32'd7);
        chk("a6b0_ld", 32'(lds), DzEn ? 32'd0 : 32'd1);

        // Reset mid-RUN: the in-flight division must vanish.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a     = 4'd13;
        in_b     = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("midrun");
        @(negedge clk);
        rst = 1'b1;
        repeat (15) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(out_valid), 32'd0);
            chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        end

        repeat (2000) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom);
            in_a      = 4'($urandom);
            in_b      = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom);
            out_ready = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
